// File: rtl/conv_pkg.sv
// Shared types and helpers for the wide-to-narrow serializer.
// CONV_IDLE_SYM_EN (used in conv_wn_serializer) selects idle-symbol fill on data_out.
package conv_pkg;

    typedef enum logic {StIdle, StSend} state_e;

    localparam logic [7:0] IDLE_SYM_DEFAULT = 8'hBC;

    function automatic int unsigned ratio(input int unsigned in_w, input int unsigned out_w);
        return in_w / out_w;
    endfunction

    // Keeps the counter at least one bit wide so RATIO == 1 still elaborates.
    function automatic int unsigned cnt_w(input int unsigned r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

    function automatic bit width_ok(input int unsigned in_w, input int unsigned out_w);
        return (out_w != 0) && ((in_w % out_w) == 0);
    endfunction

endpackage

// File: rtl/conv_wn_serializer_if.sv
// Word-in / slice-out handshake bundle for conv_wn_serializer.
interface conv_wn_serializer_if
    import conv_pkg::*;
#(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 8
);
    localparam int unsigned LW = cnt_w(ratio(IN_W, OUT_W));

    logic [IN_W-1:0]  data_in;
    logic             valid_in;
    logic             ready_out;
    logic [OUT_W-1:0] data_out;
    logic             valid_out;
    logic             ready_in;
    logic [LW-1:0]    lane_out;
    logic             last_out;

    modport master (
        output data_in, valid_in, ready_in,
        input  ready_out, data_out, valid_out, lane_out, last_out
    );

    modport slave (
        input  data_in, valid_in, ready_in,
        output ready_out, data_out, valid_out, lane_out, last_out
    );

endinterface

// File: rtl/conv_hold_buf.sv
// Single-entry holding register; ready_out is derived from its valid flag only.
module conv_hold_buf #(
    parameter int unsigned W = 32
) (
    input  logic         clk_4f,
    input  logic         reset_L,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         drain,
    output logic [W-1:0] hb_data,
    output logic         hb_valid,
    output logic         ready_out
);

    logic [W-1:0] data_q;
    logic         valid_q;

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (load) begin
                data_q <= load_data;
            end
            if (drain) begin
                valid_q <= 1'b0;
            end else if (load) begin
                valid_q <= 1'b1;
            end
        end
    end

    assign hb_data   = data_q;
    assign hb_valid  = valid_q;
    assign ready_out = !valid_q;

endmodule

// File: rtl/conv_wn_serializer.sv
// IN_W-to-OUT_W serializer, MSB slice first, with a one-word holding buffer.
// Define CONV_IDLE_SYM_EN to drive IDLE_SYM on data_out while valid_out is low.
module conv_wn_serializer
    import conv_pkg::*;
#(
    parameter int unsigned      IN_W     = 32,
    parameter int unsigned      OUT_W    = 8,
    parameter logic [OUT_W-1:0] IDLE_SYM = OUT_W'(IDLE_SYM_DEFAULT)
) (
    input  logic                clk_4f,
    input  logic                reset_L,
    conv_wn_serializer_if.slave bus
);

    localparam int unsigned RATIO = ratio(IN_W, OUT_W);
    localparam int unsigned CW    = cnt_w(RATIO);

    if (!width_ok(IN_W, OUT_W)) begin : g_width_check
        $error("conv_wn_serializer: IN_W must be an integer multiple of OUT_W");
    end

`ifdef CONV_IDLE_SYM_EN
    localparam logic [OUT_W-1:0] IDLE_FILL = IDLE_SYM;
`else
    localparam logic [OUT_W-1:0] IDLE_FILL = IDLE_SYM & {OUT_W{1'b0}};
`endif

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IN_W-1:0] sr_q, sr_d;

    logic            hb_load, hb_drain, hb_valid;
    logic [IN_W-1:0] hb_data;
    logic            accept, slice_done, at_last;

    conv_hold_buf #(
        .W (IN_W)
    ) u_hold_buf (
        .clk_4f    (clk_4f),
        .reset_L   (reset_L),
        .load      (hb_load),
        .load_data (bus.data_in),
        .drain     (hb_drain),
        .hb_data   (hb_data),
        .hb_valid  (hb_valid),
        .ready_out (bus.ready_out)
    );

    assign accept     = bus.valid_in && bus.ready_out;
    assign slice_done = bus.valid_out && bus.ready_in;
    assign at_last    = (cnt_q == CW'(RATIO - 1));

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        hb_load  = 1'b0;
        hb_drain = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sr_d    = bus.data_in;
                    cnt_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (slice_done && !at_last) begin
                    cnt_d   = cnt_q + 1'b1;
                    sr_d    = sr_q << OUT_W;
                    hb_load = accept;
                end else if (slice_done && hb_valid) begin
                    // ready_out is low here, so no new word can arrive this edge
                    sr_d     = hb_data;
                    cnt_d    = '0;
                    hb_drain = 1'b1;
                end else if (slice_done && accept) begin
                    sr_d  = bus.data_in;
                    cnt_d = '0;
                end else if (slice_done) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    hb_load = accept;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.valid_out = (state_q == StSend);
        bus.data_out  = bus.valid_out ? sr_q[IN_W-1 -: OUT_W] : IDLE_FILL;
        bus.lane_out  = bus.valid_out ? cnt_q : '0;
        bus.last_out  = bus.valid_out && at_last;
    end

endmodule

// File: tb/tb_conv_wn_serializer.sv
// Directed self-checking bench for conv_wn_serializer at 32/8, 64/16 and 16/16.
module tb_conv_wn_serializer;

    logic clk_4f = 1'b0;
    logic reset_L = 1'b0;
    int   checks = 0;
    int   failures = 0;

`ifdef CONV_IDLE_SYM_EN
    localparam logic [7:0]  IDLE8  = 8'hBC;
    localparam logic [15:0] IDLE16 = 16'h00BC;
`else
    localparam logic [7:0]  IDLE8  = 8'h00;
    localparam logic [15:0] IDLE16 = 16'h0000;
`endif

    always #5 clk_4f = ~clk_4f;

    conv_wn_serializer_if #(.IN_W(32), .OUT_W(8))  b32 ();
    conv_wn_serializer_if #(.IN_W(64), .OUT_W(16)) b64 ();
    conv_wn_serializer_if #(.IN_W(16), .OUT_W(16)) b16 ();

    conv_wn_serializer #(.IN_W(32), .OUT_W(8)) u_dut32 (
        .clk_4f (clk_4f), .reset_L (reset_L), .bus (b32)
    );
    conv_wn_serializer #(.IN_W(64), .OUT_W(16)) u_dut64 (
        .clk_4f (clk_4f), .reset_L (reset_L), .bus (b64)
    );
    conv_wn_serializer #(.IN_W(16), .OUT_W(16)) u_dut16 (
        .clk_4f (clk_4f), .reset_L (reset_L), .bus (b16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_4f);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [7:0] d, input int lane, input bit last);
        chk({tag, ".valid"}, 64'(b32.valid_out), 64'(1));
        chk({tag, ".data"},  64'(b32.data_out),  64'(d));
        chk({tag, ".lane"},  64'(b32.lane_out),  64'(lane));
        chk({tag, ".last"},  64'(b32.last_out),  64'(last));
    endtask

    task automatic chk32_idle(input string tag);
        chk({tag, ".valid"}, 64'(b32.valid_out), 64'(0));
        chk({tag, ".data"},  64'(b32.data_out),  64'(IDLE8));
        chk({tag, ".lane"},  64'(b32.lane_out),  64'(0));
        chk({tag, ".last"},  64'(b32.last_out),  64'(0));
    endtask

    logic [7:0]  exp_one  [4];
    logic [7:0]  exp_str  [8];
    logic        exp_rdy  [8];
    logic [15:0] exp_w64  [4];

    initial begin
        exp_one = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        exp_str = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_w64 = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};

        b32.data_in = '0; b32.valid_in = 1'b0; b32.ready_in = 1'b1;
        b64.data_in = '0; b64.valid_in = 1'b0; b64.ready_in = 1'b1;
        b16.data_in = '0; b16.valid_in = 1'b0; b16.ready_in = 1'b1;

        // Reset and idle
        #2;
        chk32_idle("rst");
        chk("rst.ready_out", 64'(b32.ready_out), 64'(1));
        #10 reset_L = 1'b1;
        tick();
        tick();
        chk32_idle("idle");
        chk("idle.ready_out", 64'(b32.ready_out), 64'(1));

        // Single word
        b32.data_in = 32'hDEADBEEF; b32.valid_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            b32.valid_in = 1'b0;
            chk32($sformatf("single[%0d]", i), exp_one[i], i, i == 3);
        end
        tick();
        chk32_idle("single.after");

        // Back-to-back streaming through the holding buffer
        b32.data_in = 32'h01234567; b32.valid_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) b32.data_in = 32'h89ABCDEF;
            if (i == 1) b32.valid_in = 1'b0;
            chk32($sformatf("stream[%0d]", i), exp_str[i], i % 4, (i % 4) == 3);
            chk($sformatf("stream[%0d].ready_out", i), 64'(b32.ready_out), 64'(exp_rdy[i]));
        end
        tick();
        chk32_idle("stream.after");

        // Back-pressure on lane 1
        b32.data_in = 32'hCAFEF00D; b32.valid_in = 1'b1;
        tick();
        b32.valid_in = 1'b0;
        chk32("bp.lane0", 8'hCA, 0, 1'b0);
        tick();
        chk32("bp.lane1", 8'hFE, 1, 1'b0);
        b32.ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk32($sformatf("bp.hold[%0d]", i), 8'hFE, 1, 1'b0);
        end
        b32.ready_in = 1'b1;
        tick();
        chk32("bp.lane2", 8'hF0, 2, 1'b0);
        tick();
        chk32("bp.lane3", 8'h0D, 3, 1'b1);
        tick();
        chk32_idle("bp.after");

        // Reset mid-word with a full holding buffer
        b32.data_in = 32'h11223344; b32.valid_in = 1'b1;
        tick();
        chk32("rmw.lane0", 8'h11, 0, 1'b0);
        b32.data_in = 32'h55667788;
        tick();
        b32.valid_in = 1'b0;
        chk32("rmw.lane1", 8'h22, 1, 1'b0);
        chk("rmw.hb_full", 64'(b32.ready_out), 64'(0));
        tick();
        chk32("rmw.lane2", 8'h33, 2, 1'b0);
        #2 reset_L = 1'b0;
        #1;
        chk32_idle("rmw.async");
        chk("rmw.ready_out", 64'(b32.ready_out), 64'(1));
        #2 reset_L = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rmw.quiet[%0d]", i), 64'(b32.valid_out), 64'(0));
        end
        b32.data_in = 32'hA55A0FF0; b32.valid_in = 1'b1;
        tick();
        b32.valid_in = 1'b0;
        chk32("rmw.new0", 8'hA5, 0, 1'b0);
        tick(); tick(); tick();
        chk32("rmw.new3", 8'hF0, 3, 1'b1);
        tick();
        chk32_idle("rmw.after");

        // 64/16
        b64.data_in = 64'h0123456789ABCDEF; b64.valid_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            b64.valid_in = 1'b0;
            chk($sformatf("w64[%0d].valid", i), 64'(b64.valid_out), 64'(1));
            chk($sformatf("w64[%0d].data", i),  64'(b64.data_out),  64'(exp_w64[i]));
            chk($sformatf("w64[%0d].lane", i),  64'(b64.lane_out),  64'(i));
            chk($sformatf("w64[%0d].last", i),  64'(b64.last_out),  64'(i == 3));
        end
        tick();
        chk("w64.after.valid", 64'(b64.valid_out), 64'(0));
        chk("w64.after.data",  64'(b64.data_out),  64'(IDLE16));

        // 16/16 pass-through, back-to-back
        b16.data_in = 16'hBEEF; b16.valid_in = 1'b1;
        tick();
        chk("w16[0].valid", 64'(b16.valid_out), 64'(1));
        chk("w16[0].data",  64'(b16.data_out),  64'(16'hBEEF));
        chk("w16[0].lane",  64'(b16.lane_out),  64'(0));
        chk("w16[0].last",  64'(b16.last_out),  64'(1));
        chk("w16[0].ready_out", 64'(b16.ready_out), 64'(1));
        b16.data_in = 16'h1234;
        tick();
        b16.valid_in = 1'b0;
        chk("w16[1].valid", 64'(b16.valid_out), 64'(1));
        chk("w16[1].data",  64'(b16.data_out),  64'(16'h1234));
        chk("w16[1].last",  64'(b16.last_out),  64'(1));
        tick();
        chk("w16.after.valid", 64'(b16.valid_out), 64'(0));
        chk("w16.after.data",  64'(b16.data_out),  64'(IDLE16));
        chk("w16.after.last",  64'(b16.last_out),  64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_wn_serializer.md
# conv_wn_serializer

Parametrised wide-to-narrow word serializer: accepts IN_W-bit words and emits them as RATIO = IN_W/OUT_W slices of OUT_W bits, one slice per clk_4f cycle, MSB slice first. It is the next-generation 32b→8b converter on the transmit path, feeding the byte-lane logic. It adds three things the previous converter lacked: ready/valid back-pressure on both sides, a one-word holding buffer for gap-free streaming, and per-slice lane and last markers.

## Interface
- IN_W, 32, input word width; must be an integer multiple of OUT_W
- OUT_W, 8, output slice width
- IDLE_SYM, 8'hBC, OUT_W-bit idle symbol; used only with CONV_IDLE_SYM_EN
- clk_4f  in  1  single clock, slice rate
- reset_L  in  1  asynchronous, active-low reset
- data_in  in  IN_W  input word
- valid_in  in  1  data_in valid
- ready_out  out  1  block can accept a word this cycle
- data_out  out  OUT_W  current slice
- valid_out  out  1  data_out valid
- ready_in  in  1  downstream accepts the slice
- lane_out  out  clog2(RATIO)  index of the current slice; 0 = MSB slice
- last_out  out  1  current slice is lane RATIO-1

## Operation
- Derived constant: RATIO = IN_W/OUT_W. Counter width CW = max(1, clog2(RATIO)). RATIO == 1 degenerates to a registered pass-through with handshake.
- A word is accepted on an edge where valid_in && ready_out.
- A slice completes on an edge where valid_out && ready_in.
- Storage: shift register SR (IN_W bits) plus holding register HB (IN_W bits, 1 valid bit).
- ready_out = !HB.valid. ready_out is registered-state-derived only; it has no combinational path from ready_in.
- FSM states:
  - IDLE: SR is empty.
  - SEND: SR holds a word; slice index is cnt.
- IDLE → SEND: on a word acceptance. The word loads SR directly (HB is bypassed) and cnt is set to 0.
- SEND, slice completes with cnt < RATIO-1: cnt increments and SR shifts left by OUT_W.
- SEND, last slice completes, HB.valid = 1: HB moves to SR, cnt is set to 0, state stays SEND.
- SEND, last slice completes, HB empty, word accepted the same edge: data_in loads SR directly, state stays SEND.
- SEND, last slice completes, HB empty, no acceptance: → IDLE.
- A word accepted while in SEND that is not absorbed by the cases above goes to HB.
- Output mapping:
  - data_out = SR[IN_W-1 -: OUT_W]
  - lane_out = cnt
  - last_out = valid_out && (cnt == RATIO-1)
  - valid_out = (state == SEND)
- Back-pressure: while valid_out && !ready_in, data_out, lane_out and last_out are held stable.
- Idle output: when valid_out = 0, data_out = 0, lane_out = 0, last_out = 0.

## Timing
- Reset (reset_L low, asynchronous): state = IDLE, cnt = 0, HB.valid = 0, valid_out = 0, data_out = 0 (IDLE_SYM with macro), lane_out = 0, last_out = 0, ready_out = 1.
- Reset mid-word discards both the partial word and HB contents. Reset release is synchronous to clk_4f.
- Latency: a word accepted at edge k shows slice 0 after edge k and slice RATIO-1 after edge k+RATIO-1, given ready_in held high.
- Throughput: one word per RATIO cycles with no bubble, provided each next word arrives before its predecessor's last slice completes.
- ready_out drops the cycle after HB fills. It rises the cycle after HB drains into SR.

## Configuration
- CONV_IDLE_SYM_EN defined: when valid_out = 0, data_out = IDLE_SYM. This includes the reset value and idle gaps, giving the link a comma/idle fill.
- CONV_IDLE_SYM_EN undefined: when valid_out = 0, data_out = 0. The IDLE_SYM parameter is ignored.

## Structure
- Package conv_pkg holds:
  - function ratio(IN_W, OUT_W) and the cnt width helper
  - state typedef {IDLE, SEND}
  - the default IDLE_SYM = 8'hBC
  - an elaboration check that IN_W % OUT_W == 0
- One natural sub-module: conv_hold_buf, the single-entry holding register with valid flag and the ready_out generation. The FSM, SR and cnt stay in conv_wn_serializer.

## Test plan
- Reset and idle: reset_L low, then high, valid_in = 0.
  - data_out = 8'h00 (8'hBC with macro), valid_out = 0, ready_out = 1.
- Single word 32'hDEADBEEF, ready_in = 1:
  - Slices DE, AD, BE, EF on 4 consecutive cycles, lane_out 0..3, last_out only with EF.
  - Then valid_out = 0.
- Back-to-back streaming: words 32'h01234567 and 32'h89ABCDEF, valid_in held high.
  - 8 contiguous slices 01 23 45 67 89 AB CD EF with no bubble.
  - ready_out low while HB is full.
- Back-pressure: ready_in = 0 for 3 cycles while lane 1 of 32'hCAFEF00D is presented.
  - data_out stays FE, lane_out stays 1.
  - Sequence resumes F0, 0D, with no slice lost or duplicated.
- Reset mid-word: reset_L pulsed low after slice 2 of 32'h11223344, with HB holding 32'h55667788.
  - Outputs go to reset values immediately. Nothing further is emitted until a new word is accepted.
- Parameter sweep: IN_W = 64 with OUT_W = 16, and IN_W = 16 with OUT_W = 16.
  - 64/16: 4 slices, MSB first.
  - 16/16: RATIO = 1, single-cycle pass-through, last_out = 1 on every slice.
